rom_bank_sched: RTL and testbench
=================================

Name: rom_bank_sched

Overview:
- Sequences ownership of the shared serial instruction line `is` among up to 8 ROM chips. It tracks the 56-state word time and captures each 10-bit instruction.
- It decodes ROM-select, delayed-select, JSB/GTO and RTN instructions, then grants exactly one ROM the right to drive `is` in each instruction window.
- It sits beside the control/timing block on `cph2`. ROMs use `rom_oe` as their output enable.

Parameters:
- NROM, 8, number of ROM banks (2..8); bank indices 0..NROM-1.
- RST_BANK, 0, bank selected after reset; must be < NROM.

Ports:
- cph2  in  1  system clock; all state updates on rising edge.
- nrst  in  1  asynchronous active-low reset.
- is  in  1  serial instruction line, LSB first.
- rom_oe  out  NROM  one-hot drive enable for the granted ROM, instruction window only.
- bank  out  3  currently granted bank.
- sync  out  1  high while word counter is 45..54.
- word_start  out  1  high while word counter is 0.
- sel_pend  out  1  a delayed select is armed.
- bank_err  out  1  one-cycle pulse when a select names bank >= NROM.

Behaviour:
- Reset values (async, on nrst low):
  - cnt = 0; bank = RST_BANK; ret_bank = RST_BANK.
  - sel_pend = 0; pend_bank = 0; ir = 0; bank_err = 0.
  - Outputs are then word_start = 1, sync = 0, rom_oe = 0.
  - Reset mid-word discards any partial instruction and any armed select.
- Word counter:
  - 6-bit `cnt` counts 0..55, wraps 55->0, free-running after reset release.
  - `sync` = (45 <= cnt <= 54); `word_start` = (cnt == 0).
- Capture:
  - On each edge with cnt in 45..54, shift `is` into 10-bit `ir`, LSB first: the bit sampled at cnt=45 becomes I[0] and the bit at cnt=54 becomes I[9].
  - `ir` holds outside the window.
- Decode (combinational on `ir`; used only on the edge where cnt == 55):
  - JSB: I[1:0] = 01.
  - GTO: I[1:0] = 11.
  - RTN: I[1:0] = 00, I[5:2] = 1100, I[9] = 0.
  - SEL (immediate): I[1:0] = 00, I[6:2] = 10000; target n = I[9:7].
  - DSEL (delayed): I[1:0] = 00, I[6:2] = 10100; target n = I[9:7].
  - Any other code: no action.
- Commit on the cnt==55 edge, first match wins. The new `bank` is visible from cnt == 0, so it governs the next instruction window.
  1. SEL, n < NROM: bank <= n; sel_pend <= 0.
  2. SEL or DSEL, n >= NROM: no state change; bank_err = 1 for the single cycle cnt == 0.
  3. DSEL, n < NROM: pend_bank <= n; sel_pend <= 1. A second DSEL overwrites pend_bank.
  4. JSB or GTO with sel_pend = 1: bank <= pend_bank; sel_pend <= 0. On JSB also ret_bank <= old bank.
  5. JSB with sel_pend = 0: ret_bank <= bank; bank unchanged.
  6. RTN: bank <= ret_bank. sel_pend is unaffected.
- Return stack:
  - ret_bank is a single level; a nested JSB overwrites it.
  - RTN with no prior JSB restores RST_BANK.
- Grant:
  - rom_oe[k] = sync && (bank == k). It is never multi-hot and is all-zero outside 45..54.
  - `bank` changes only at the 55->0 boundary, so the grant never switches mid-instruction.
- Power-on: the first window after reset grants RST_BANK, whatever value `is` carries.

Test Plan:
- Reset and timing: release nrst, run 112 cycles. Required: sync high exactly at cnt 45..54 twice, word_start at cnt 0 twice, rom_oe = 8'b00000001 only during sync.
- Immediate select: drive I = 10'b011_10000_00 in word 1. Required: from word 2 cnt 0, bank = 3 and rom_oe = 8'b00001000 during 45..54. Word 1's window still grants bank 0.
- Delayed select, then JSB, then RTN:
  - Word 1: DSEL bank 5 (10'b101_10100_00). Word 2: bank stays 0 and sel_pend = 1.
  - Word 2: JSB (I[1:0] = 01). Word 3: bank = 5 and sel_pend = 0.
  - Word 3: RTN (10'b0000110000). Word 4: bank = 0.
- Out of range: NROM = 4, SEL n = 6 (10'b110_10000_00). Required: bank_err pulses for one cycle at the next cnt 0, and bank is unchanged.
- Precedence: with sel_pend = 1 (pend_bank = 2), issue SEL n = 1. Required: bank = 1, sel_pend = 0; a later GTO leaves bank = 1.
- Reset mid-capture: assert nrst at cnt = 50 of a SEL 3 word. Required: all reset values immediately, bank = RST_BANK, and the partial instruction has no effect.

Source files
------------

// File: rtl/rom_bank_sched.sv
// rom_bank_sched: tracks the 56-state word time, captures each serial instruction
// and grants exactly one ROM bank the shared is line in every instruction window.
module rom_bank_sched #(
  parameter int NROM     = 8,
  parameter int RST_BANK = 0
) (
  input  logic            cph2,
  input  logic            nrst,
  input  logic            is,
  output logic [NROM-1:0] rom_oe,
  output logic [2:0]      bank,
  output logic            sync,
  output logic            word_start,
  output logic            sel_pend,
  output logic            bank_err
);
  localparam logic [5:0] CNT_LAST = 6'd55;
  localparam logic [2:0] RST_B    = 3'(RST_BANK);
  localparam logic [3:0] NROM_W   = 4'(NROM);

  logic [5:0] r_cnt;
  logic [9:0] r_ir;
  logic [2:0] r_bank, r_ret_bank, r_pend_bank;
  logic       r_sel_pend, r_bank_err;

  logic [2:0] w_bank_nxt, w_ret_nxt, w_pend_nxt, w_n;
  logic       w_sel_pend_nxt, w_err_nxt;
  logic       w_win, w_commit, w_n_ok;
  logic       w_jsb, w_gto, w_rtn, w_sel, w_dsel;

  assign w_win    = (r_cnt >= 6'd45) && (r_cnt <= 6'd54);
  assign w_commit = (r_cnt == CNT_LAST);
  assign w_n      = r_ir[9:7];
  assign w_n_ok   = ({1'b0, w_n} < NROM_W);

  assign w_jsb  = (r_ir[1:0] == 2'b01);
  assign w_gto  = (r_ir[1:0] == 2'b11);
  assign w_rtn  = (r_ir[1:0] == 2'b00) && (r_ir[5:2] == 4'b1100) && !r_ir[9];
  assign w_sel  = (r_ir[1:0] == 2'b00) && (r_ir[6:2] == 5'b10000);
  assign w_dsel = (r_ir[1:0] == 2'b00) && (r_ir[6:2] == 5'b10100);

  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      r_cnt       <= '0;
      r_ir        <= '0;
      r_bank      <= RST_B;
      r_ret_bank  <= RST_B;
      r_pend_bank <= '0;
      r_sel_pend  <= 1'b0;
      r_bank_err  <= 1'b0;
    end else begin
      r_cnt <= w_commit ? 6'd0 : r_cnt + 6'd1;
      // LSB arrives first, so shift in from the top
      if (w_win) r_ir <= {is, r_ir[9:1]};
      r_bank      <= w_bank_nxt;
      r_ret_bank  <= w_ret_nxt;
      r_pend_bank <= w_pend_nxt;
      r_sel_pend  <= w_sel_pend_nxt;
      r_bank_err  <= w_err_nxt;
    end
  end

  // Bank bookkeeping only moves on the 55->0 edge, so a grant never changes mid-window
  always_comb begin
    w_bank_nxt     = r_bank;
    w_ret_nxt      = r_ret_bank;
    w_pend_nxt     = r_pend_bank;
    w_sel_pend_nxt = r_sel_pend;
    w_err_nxt      = 1'b0;
    if (w_commit) begin
      if (w_sel && w_n_ok) begin
        w_bank_nxt     = w_n;
        w_sel_pend_nxt = 1'b0;
      end else if ((w_sel || w_dsel) && !w_n_ok) begin
        w_err_nxt = 1'b1;
      end else if (w_dsel) begin
        w_pend_nxt     = w_n;
        w_sel_pend_nxt = 1'b1;
      end else if ((w_jsb || w_gto) && r_sel_pend) begin
        w_bank_nxt     = r_pend_bank;
        w_sel_pend_nxt = 1'b0;
        if (w_jsb) w_ret_nxt = r_bank;
      end else if (w_jsb) begin
        w_ret_nxt = r_bank;
      end else if (w_rtn) begin
        w_bank_nxt = r_ret_bank;
      end
    end
  end

  always_comb begin
    rom_oe = '0;
    for (int k = 0; k < NROM; k++) begin
      if (w_win && (r_bank == 3'(k))) rom_oe[k] = 1'b1;
    end
    sync       = w_win;
    word_start = (r_cnt == 6'd0);
    bank       = r_bank;
    sel_pend   = r_sel_pend;
    bank_err   = r_bank_err;
  end
endmodule

// File: tb/tb_rom_bank_sched.sv
// Bench for rom_bank_sched: an 8-bank and a 4-bank instance share stimulus; a monitor
// checks every cycle against expectations queued per instruction word.
module tb_rom_bank_sched;
  logic       cph2 = 1'b0;
  logic       nrst = 1'b0;
  logic       is   = 1'b0;
  logic [7:0] rom_oe8;
  logic [3:0] rom_oe4;
  logic [2:0] bank8, bank4;
  logic       sync8, sync4, ws8, ws4, sp8, sp4, err8, err4;

  rom_bank_sched #(.NROM(8), .RST_BANK(0)) dut8 (
    .cph2(cph2), .nrst(nrst), .is(is), .rom_oe(rom_oe8), .bank(bank8),
    .sync(sync8), .word_start(ws8), .sel_pend(sp8), .bank_err(err8));

  rom_bank_sched #(.NROM(4), .RST_BANK(0)) dut4 (
    .cph2(cph2), .nrst(nrst), .is(is), .rom_oe(rom_oe4), .bank(bank4),
    .sync(sync4), .word_start(ws4), .sel_pend(sp4), .bank_err(err4));

  always #5 cph2 = ~cph2;

  typedef struct packed {
    logic [2:0] b8; logic sp8; logic e8;
    logic [2:0] b4; logic sp4; logic e4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [2:0] b8, input logic s8, input logic e8,
                              input logic [2:0] b4, input logic s4, input logic e4);
    exp_t e;
    e.b8 = b8; e.sp8 = s8; e.e8 = e8; e.b4 = b4; e.sp4 = s4; e.e4 = e4;
    return e;
  endfunction

  function automatic logic [9:0] f_sel(input logic [2:0] n);
    return {n, 5'b10000, 2'b00};
  endfunction
  function automatic logic [9:0] f_dsel(input logic [2:0] n);
    return {n, 5'b10100, 2'b00};
  endfunction
  localparam logic [9:0] NOP = 10'b0000000000;
  localparam logic [9:0] JSB = 10'b0000000001;
  localparam logic [9:0] GTO = 10'b0000000011;
  localparam logic [9:0] RTN = 10'b0000110000;

  // Called at a negedge with DUT cnt == 0; returns at the negedge after the 55->0 wrap.
  // Bits outside the window toggle so stray captures would show up.
  task automatic do_word(input logic [9:0] ins, input exp_t e);
    sb.push_back(e);
    for (int c = 0; c < 56; c++) begin
      is = (c >= 45 && c <= 54) ? ins[c-45] : 1'(c & 1);
      @(negedge cph2);
    end
  endtask

  // Monitor: independent cycle model, expectations popped at every word start
  int         m_cnt;
  exp_t       m_e;
  initial begin
    m_cnt = 0;
    m_e   = mk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    forever begin
      @(posedge cph2);
      #1;
      if (!nrst) begin
        m_cnt = 0;
        m_e   = mk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      end else begin
        m_cnt = (m_cnt == 55) ? 0 : m_cnt + 1;
        if (m_cnt == 0) begin
          if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
          else m_e = sb.pop_front();
        end
        chk("sync8", 32'(sync8), 32'(m_cnt >= 45 && m_cnt <= 54));
        chk("sync4", 32'(sync4), 32'(m_cnt >= 45 && m_cnt <= 54));
        chk("word_start8", 32'(ws8), 32'(m_cnt == 0));
        chk("word_start4", 32'(ws4), 32'(m_cnt == 0));
        chk("bank8", 32'(bank8), 32'(m_e.b8));
        chk("bank4", 32'(bank4), 32'(m_e.b4));
        chk("sel_pend8", 32'(sp8), 32'(m_e.sp8));
        chk("sel_pend4", 32'(sp4), 32'(m_e.sp4));
        chk("bank_err8", 32'(err8), 32'(m_cnt == 0 && m_e.e8));
        chk("bank_err4", 32'(err4), 32'(m_cnt == 0 && m_e.e4));
        chk("rom_oe8", 32'(rom_oe8),
            (m_cnt >= 45 && m_cnt <= 54) ? 32'(8'b1 << m_e.b8) : 32'(0));
        chk("rom_oe4", 32'(rom_oe4),
            (m_cnt >= 45 && m_cnt <= 54) ? 32'(4'b1 << m_e.b4) : 32'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] part;
    nrst = 1'b0;
    is   = 1'b0;
    #2;
    chk("rst_bank8", 32'(bank8), 32'(0));
    chk("rst_ws8", 32'(ws8), 32'(1));
    chk("rst_oe8", 32'(rom_oe8), 32'(0));
    repeat (3) @(negedge cph2);
    nrst = 1'b1;

    // power-on / timing, then immediate select
    do_word(NOP,        mk(3'd0, 0, 0, 3'd0, 0, 0));
    do_word(NOP,        mk(3'd0, 0, 0, 3'd0, 0, 0));
    do_word(f_sel(3),   mk(3'd3, 0, 0, 3'd3, 0, 0));
    do_word(f_sel(0),   mk(3'd0, 0, 0, 3'd0, 0, 0));
    // delayed select, JSB, RTN (5 is out of range for the 4-bank part)
    do_word(f_dsel(5),  mk(3'd0, 1, 0, 3'd0, 0, 1));
    do_word(JSB,        mk(3'd5, 0, 0, 3'd0, 0, 0));
    do_word(RTN,        mk(3'd0, 0, 0, 3'd0, 0, 0));
    // out of range for 4 banks
    do_word(f_sel(6),   mk(3'd6, 0, 0, 3'd0, 0, 1));
    // precedence: SEL cancels armed DSEL, later GTO does nothing
    do_word(f_dsel(2),  mk(3'd6, 1, 0, 3'd0, 1, 0));
    do_word(f_sel(1),   mk(3'd1, 0, 0, 3'd1, 0, 0));
    do_word(GTO,        mk(3'd1, 0, 0, 3'd1, 0, 0));
    // single-level return
    do_word(JSB,        mk(3'd1, 0, 0, 3'd1, 0, 0));
    do_word(f_sel(2),   mk(3'd2, 0, 0, 3'd2, 0, 0));
    do_word(RTN,        mk(3'd1, 0, 0, 3'd1, 0, 0));
    // DSEL overwrite; out-of-range DSEL leaves the 4-bank pend alone
    do_word(f_dsel(3),  mk(3'd1, 1, 0, 3'd1, 1, 0));
    do_word(f_dsel(6),  mk(3'd1, 1, 0, 3'd1, 1, 1));
    do_word(GTO,        mk(3'd6, 0, 0, 3'd3, 0, 0));
    do_word(RTN,        mk(3'd1, 0, 0, 3'd1, 0, 0));
    // JSB with a pending select records the old bank
    do_word(f_sel(2),   mk(3'd2, 0, 0, 3'd2, 0, 0));
    do_word(f_dsel(1),  mk(3'd2, 1, 0, 3'd2, 1, 0));
    do_word(JSB,        mk(3'd1, 0, 0, 3'd1, 0, 0));
    do_word(RTN,        mk(3'd2, 0, 0, 3'd2, 0, 0));
    // arm a select, then reset at cnt 50 of a SEL 3 word
    do_word(f_dsel(1),  mk(3'd2, 1, 0, 3'd2, 1, 0));
    part = f_sel(3);
    for (int c = 0; c < 50; c++) begin
      is = (c >= 45) ? part[c-45] : 1'b0;
      @(negedge cph2);
    end
    nrst = 1'b0;
    #1;
    chk("midrst_bank8", 32'(bank8), 32'(0));
    chk("midrst_bank4", 32'(bank4), 32'(0));
    chk("midrst_sp8", 32'(sp8), 32'(0));
    chk("midrst_ws8", 32'(ws8), 32'(1));
    chk("midrst_sync8", 32'(sync8), 32'(0));
    chk("midrst_oe8", 32'(rom_oe8), 32'(0));
    chk("midrst_err8", 32'(err8), 32'(0));
    repeat (2) @(negedge cph2);
    nrst = 1'b1;
    // armed select discarded; RTN with no JSB since reset returns to bank 0
    do_word(GTO,        mk(3'd0, 0, 0, 3'd0, 0, 0));
    do_word(f_sel(7),   mk(3'd7, 0, 0, 3'd0, 0, 1));
    do_word(RTN,        mk(3'd0, 0, 0, 3'd0, 0, 0));

    repeat (3) @(negedge cph2);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
